// File: rtl/csr_pkg.sv
// Shared CSR definitions: FSM state encoding and element width.
package csr_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} csr_state_t;
endpackage

// File: rtl/csr_index_counter.sv
// Row/column position of the next element in a row-major stream.
module csr_index_counter #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_adv,
  output logic [31:0] o_row,
  output logic [31:0] o_col,
  output logic        o_row_end,
  output logic        o_mat_end
);
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic        w_row_end;

  assign w_row_end = (r_col == 32'(M - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_row_end) begin
        r_col <= '0;
        r_row <= r_row + 32'd1;
      end else begin
        r_col <= r_col + 32'd1;
      end
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_row_end = w_row_end;
  assign o_mat_end = w_row_end && (r_row == 32'(N - 1));
endmodule

// File: rtl/csr_encoder.sv
// Dense row-major stream to CSR (val/col/rowPtr) writer with sticky capacity overflow.
module csr_encoder
  import csr_pkg::*;
#(
  parameter int n   = 4,
  parameter int m   = 4,
  parameter int nnz = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [31:0]       val       [nnz],
  output logic [31:0]       col       [nnz],
  output logic [31:0]       rowPtr    [n+1],
  output logic [31:0]       nnz_count,
  output logic              done,
  output logic              overflow
);
  localparam int unsigned NNZ_U = nnz;
  localparam int unsigned ROWS_U = n;

  csr_state_t  r_state;
  csr_state_t  w_next;
  logic [31:0] r_val [nnz];
  logic [31:0] r_col [nnz];
  logic [31:0] r_rp  [n+1];
  logic [31:0] r_cnt;
  logic        r_ovf;

  logic        w_load;
  logic        w_accept;
  logic        w_nz;
  logic        w_room;
  logic [31:0] w_cnt_next;
  logic [31:0] w_row;
  logic [31:0] w_colidx;
  logic        w_row_end;
  logic        w_mat_end;

  assign w_load     = start && (r_state != LOAD);
  assign w_accept   = in_valid && in_ready;
  assign w_nz       = (in_data != '0);
  assign w_room     = (r_cnt < 32'(nnz));
  assign w_cnt_next = r_cnt + {31'b0, w_nz && w_room};

  csr_index_counter #(
    .N (n),
    .M (m)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_load),
    .i_adv     (w_accept),
    .o_row     (w_row),
    .o_col     (w_colidx),
    .o_row_end (w_row_end),
    .o_mat_end (w_mat_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_accept && w_mat_end) w_next = DONE;
      DONE:    if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == LOAD);
    done     = (r_state == DONE);
  end

  // Writes use compare-per-entry loops so the storage index never needs a narrowing cast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NNZ_U; i++) begin
        r_val[i] <= '0;
        r_col[i] <= '0;
      end
      for (int unsigned i = 0; i <= ROWS_U; i++) r_rp[i] <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      for (int unsigned i = 0; i < NNZ_U; i++) begin
        r_val[i] <= '0;
        r_col[i] <= '0;
      end
      for (int unsigned i = 0; i <= ROWS_U; i++) r_rp[i] <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_nz) begin
        if (w_room) begin
          for (int unsigned i = 0; i < NNZ_U; i++) begin
            if (i == r_cnt) begin
              r_val[i] <= in_data;
              r_col[i] <= w_colidx;
            end
          end
          r_cnt <= w_cnt_next;
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (w_row_end) begin
        for (int unsigned i = 1; i <= ROWS_U; i++) begin
          if (i == w_row + 32'd1) r_rp[i] <= w_cnt_next;
        end
      end
    end
  end

  assign val       = r_val;
  assign col       = r_col;
  assign rowPtr    = r_rp;
  assign nnz_count = r_cnt;
  assign overflow  = r_ovf;
endmodule
